// File: rtl/osmosis_vga_pkg.sv
// rtl/osmosis_vga_pkg.sv - default 640x480 raster timing constants shared by the display path
package osmosis_vga_pkg;

   localparam int COORD_W     = 10;
   localparam int FRAME_CNT_W = 16;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FP_DEF      = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BP_DEF      = 48;
   localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;
   localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/pix_clk_en.sv
// rtl/pix_clk_en.sv - system-clock to pixel-rate enable divider
// adv_o is the combinational "this edge is a pixel edge" strobe; tick_o is its registered copy.
module pix_clk_en #(
   parameter int CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic adv_o,
   output logic tick_o
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q;

   always_comb begin
      adv_o = (div_q == DIV_LAST);
      div_d = adv_o ? '0 : div_q + DIV_W'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tick_q <= adv_o;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - free-running raster counters, sync/blank decodes and frame strobe
// Decodes are taken from next-state counters so they register in step with h_cnt/v_cnt.
module vga_scan_gen
   import osmosis_vga_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   pix_tick,
   output logic [COORD_W-1:0]     h_cnt,
   output logic [COORD_W-1:0]     v_cnt,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   video_on,
   output logic                   frame,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
   localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_VISIBLE + H_FP);
   localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_VISIBLE + V_FP);
   localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

   logic                   adv;
   logic [COORD_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic                   hsync_q, hsync_d, vsync_q, vsync_d;
   logic                   video_on_q, video_on_d, frame_q, frame_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   pix_clk_en #(
      .CLK_DIV(CLK_DIV)
   ) u_pix_clk_en (
      .clk_i (clk),
      .rst_i (reset),
      .adv_o (adv),
      .tick_o(pix_tick)
   );

   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      frame_d     = 1'b0;
      frame_cnt_d = frame_cnt_q;
      if (adv) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COORD_W'(1);
         end else begin
            h_cnt_d = h_cnt_q + COORD_W'(1);
         end
         // Only the tick that lands on the first blanking line can strobe; the full-frame wrap cannot.
         if ((h_cnt_d == '0) && (v_cnt_d == V_VIS)) begin
            frame_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
         end
      end
      hsync_d    = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
      vsync_d    = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
      video_on_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         video_on_q  <= 1'b1;
         frame_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         video_on_q  <= video_on_d;
         frame_q     <= frame_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign h_cnt     = h_cnt_q;
   assign v_cnt     = v_cnt_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign video_on  = video_on_q;
   assign frame     = frame_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster timing generator for the 640×480 display path. It produces the `h_cnt`/`v_cnt` scan coordinates that every molecule and membrane renderer compares against its own position. It also produces the `frame` strobe that the molecule motion logic uses to step positions once per frame, plus the `hsync`/`vsync`/`video_on` signals for the VGA port. It sits at the top of the display path, between the system clock and all pixel-hit logic.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; must be ≥ 2.
- `H_VISIBLE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Ports:
- `clk` in, 1 bit: system clock.
- `reset` in, 1 bit: asynchronous, active-high.
- `pix_tick` out, 1 bit: one-`clk` pixel enable.
- `h_cnt` out, 10 bits: horizontal position, 0..H_TOTAL-1.
- `v_cnt` out, 10 bits: vertical position, 0..V_TOTAL-1.
- `hsync` out, 1 bit: horizontal sync, active-low.
- `vsync` out, 1 bit: vertical sync, active-low.
- `video_on` out, 1 bit: high inside the visible region.
- `frame` out, 1 bit: one-`clk` pulse at the start of vertical blanking.
- `frame_cnt` out, 16 bits: number of frames since reset; wraps.

## Operation
- Derived values: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP, which is 800 with the defaults. V_TOTAL is the same sum over the vertical parameters, which is 525.
- Divider: `div` counts 0..CLK_DIV-1 and wraps. `pix_tick` is a register that is high for one `clk` when `div` = CLK_DIV-1, i.e. once every CLK_DIV clocks.
- Counters change only on `pix_tick`:
  - `h_cnt` increments, and wraps from H_TOTAL-1 to 0.
  - On that wrap, `v_cnt` increments, and wraps from V_TOTAL-1 to 0.
- Decodes are functions of the `h_cnt`/`v_cnt` values visible in the same cycle:
  - `hsync` = 0 iff H_VISIBLE+H_FP ≤ h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
  - `vsync` = 0 iff V_VISIBLE+V_FP ≤ v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491).
  - `video_on` = (h_cnt < H_VISIBLE) & (v_cnt < V_VISIBLE).
- The decodes are registered. Compute them from the next-state counter values so they stay aligned with the counters with no one-cycle skew.
- `frame` is high for exactly the one `clk` cycle in which the counters first show h_cnt=0, v_cnt=V_VISIBLE. `frame_cnt` increments in that same cycle, which gives molecule motion the whole blanking interval before the next visible pixel.
- Counter widths: all comparisons are 10-bit unsigned. Totals must fit in 10 bits, i.e. H_TOTAL and V_TOTAL ≤ 1024.
- There is no enable or freeze input; the generator free-runs. Freezing motion is handled downstream and never stalls the raster.

## Timing
- Reset values, held while `reset` is high:
  - div=0, pix_tick=0, h_cnt=0, v_cnt=0
  - hsync=1, vsync=1, video_on=1
  - frame=0, frame_cnt=0
- Reset mid-line or mid-frame: all outputs return to their reset values immediately and asynchronously. After release, the first `pix_tick` comes CLK_DIV clocks later.
- `pix_tick` number n (n ≥ 1) after reset release is on `clk` edge n·CLK_DIV. The counters update on that same edge.
- Line period: H_TOTAL·CLK_DIV clocks (3200).
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clocks (1,680,000).
- First `frame` pulse after reset: `clk` edge H_TOTAL·V_VISIBLE·CLK_DIV (1,536,000). It never occurs earlier, even though the counters start at (0,0).
- Simultaneous h and v wrap (h=799, v=524 → 0,0): both counters update on the same tick, and `frame` is not asserted.
- `frame_cnt` wraps from 0xFFFF to 0 with no side effect.

## Structure
- Shared package `osmosis_vga_pkg` holds:
  - the default timing constants: visible sizes, porches, sync widths, H_TOTAL/V_TOTAL;
  - the 10-bit coordinate width constant, reused by the molecule renderers and their motion logic.
- One sub-module: `pix_clk_en`, the CLK_DIV enable divider with an asynchronous reset. The counter and decode logic stay in `vga_scan_gen`.

## Test plan
- Release reset and count clocks between `pix_tick` pulses → spacing is exactly 4. First tick on clock 4; `h_cnt` = 1 on that edge.
- Run one line → `h_cnt` wraps 799→0 at tick 800 and `v_cnt` becomes 1. `hsync` is low for exactly 96 ticks, from h=656 through h=751. `video_on` goes low exactly at h=640.
- Run from reset with defaults → first `frame` pulse at clock 1,536,000, one clock wide, with `frame_cnt` = 1. Second pulse 1,680,000 clocks later, with `frame_cnt` = 2. `vsync` is low only for v=490 and v=491.
- Small configuration: CLK_DIV=2, H=4/1/1/1, V=3/1/1/1 → H_TOTAL=7, V_TOTAL=6. Check full frame wrap (6,5)→(0,0) with no `frame` pulse. `frame` asserts at (0,3).
- Assert `reset` mid-line at h=300, v=200 → all outputs at their reset values in the same cycle. After release, the sequence repeats the first-tick timing.
- Force `frame_cnt` to 0xFFFF in the bench via a small configuration → next `frame` pulse sets it to 0x0000.
